rx_frame_assembler: RTL
=======================

RX_FRAME_ASSEMBLER -- requirements
Module: rx_frame_assembler

Interface
REQ-001 SHALL provide parameter SYNC_PATTERN, default 8'b1010_1011, the sync word preceding every frame, MSB received first.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 96, the maximum number of clocks between bit strobes inside a frame.
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 G_CLK_RX  input  1  receive clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 bit_valid  input  1  one-cycle strobe from the demodulator marking a decided bit.
REQ-007 bit_value  input  1  demodulated bit value, sampled only when bit_valid=1.
REQ-008 rx_enable  input  1  RXENABLE control bit; 0 idles the block.
REQ-009 int_mask  input  1  INTMASK control bit; 1 lets int_flag reach the host.
REQ-010 int_clear  input  1  one-cycle host acknowledge; clears int_flag and overrun.
REQ-011 DATA_BYTE_1  output  8  first received data byte.
REQ-012 DATA_BYTE_0  output  8  second received data byte.
REQ-013 status  output  1  STATUS bit; 1 while in RECV.
REQ-014 int_flag  output  1  INTFLAG bit; 1 when an unread frame is held.
REQ-015 int_rx_host  output  1  interrupt to host, equal to int_flag AND int_mask (combinational).
REQ-016 overrun  output  1  sticky flag; a frame completed while int_flag=1.
REQ-017 parity_err  output  1  sticky parity-failure flag; present in both builds.

Function
REQ-018 SHALL implement the FSM states IDLE, HUNT and RECV.
REQ-019 IDLE->HUNT when rx_enable=1; any state->IDLE on the first clock with rx_enable=0, discarding the partial frame and holding all outputs.
REQ-020 HUNT: each strobed bit shifts into an 8-bit sync register, LSB entry; the sync register clears on every entry to HUNT.
REQ-021 HUNT->RECV on the edge sampling the bit that makes the sync register equal SYNC_PATTERN; the next strobed bit is data bit 0.
REQ-022 RECV: data bits shift MSB-first into a 16-bit shadow register; bits 0-7 form DATA_BYTE_1[7:0] and bits 8-15 form DATA_BYTE_0[7:0].
REQ-023 Frame completion occurs on the edge sampling the last frame bit; the state then returns to HUNT.
REQ-024 At completion with int_flag=0, both bytes load from the shadow register and int_flag sets, visible in the next cycle (1-cycle latency).
REQ-025 At completion with int_flag=1, both bytes hold, the frame is discarded and overrun sets.
REQ-026 When int_clear coincides with completion, the clear is applied first: data loads, int_flag stays 1, overrun is not set.
REQ-027 A 7-bit inter-bit counter in RECV restarts on every bit_valid; reaching TIMEOUT_CYCLES returns the FSM to HUNT without updating outputs or flags.
REQ-028 bit_valid is ignored in IDLE; DATA_BYTE_x change only at a completed frame.

Reset
REQ-029 While reset_n=0: state=IDLE, sync/shadow/counters=0, DATA_BYTE_0=DATA_BYTE_1=8'h00, status=int_flag=overrun=parity_err=0, int_rx_host=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame immediately with no output update.

Configuration
REQ-031 Macro RX_PARITY_EN SHALL, when defined, add a 17th frame bit carrying even parity over the 16 data bits.
REQ-032 With RX_PARITY_EN defined, a parity mismatch discards the frame without touching the data bytes or int_flag, and sets parity_err (cleared by int_clear).
REQ-033 Without RX_PARITY_EN, frames are 16 bits, completion is on data bit 15, and parity_err is tied to 0.

Verification
REQ-034 rx_enable=1, bits 10101011 then 0x3C,0x5A (plus parity 0 if enabled) -> DATA_BYTE_1=8'h3C, DATA_BYTE_0=8'h5A, int_flag=1 one cycle after the last strobe; int_rx_host=1 only with int_mask=1.
REQ-035 Second valid frame 0xFFFF before int_clear -> bytes stay 3C/5A, overrun=1; then int_clear -> int_flag=0, overrun=0.
REQ-036 Sync, then 5 data bits, then no strobe for 96 clocks -> FSM back in HUNT, status=0, outputs unchanged; a fresh frame then completes normally.
REQ-037 rx_enable dropped after data bit 9 -> IDLE next clock, no flag; reset_n pulsed low mid-frame -> all outputs 0 asynchronously.
REQ-038 int_clear on the completion edge -> int_flag=1, overrun=0, new data loaded; RX_PARITY_EN build with a wrong parity bit -> parity_err=1, int_flag unchanged.

Source files
------------

// File: rtl/rx_frame_assembler.sv
// Serial receive frame assembler: hunts for a sync word, then collects a 16-bit frame into two host bytes.
// Optional build macro RX_PARITY_EN appends an even-parity bit to every frame.
module rx_frame_assembler #(
    parameter logic [7:0] SYNC_PATTERN   = 8'b1010_1011,
    parameter int         TIMEOUT_CYCLES = 96
) (
    input  logic       G_CLK_RX,
    input  logic       reset_n,
    input  logic       bit_valid,
    input  logic       bit_value,
    input  logic       rx_enable,
    input  logic       int_mask,
    input  logic       int_clear,
    output logic [7:0] DATA_BYTE_1,
    output logic [7:0] DATA_BYTE_0,
    output logic       status,
    output logic       int_flag,
    output logic       int_rx_host,
    output logic       overrun,
    output logic       parity_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        RECV = 2'd2
    } state_t;

`ifdef RX_PARITY_EN
    localparam int SHADOW_W = 16;
    localparam logic [4:0] LAST_BIT = 5'd16;
`else
    localparam int SHADOW_W = 15;
    localparam logic [4:0] LAST_BIT = 5'd15;
`endif
    localparam logic [6:0] GAP_LAST = 7'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [7:0]            sync_q, sync_d;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [6:0]            gap_cnt_q, gap_cnt_d;
    logic [7:0]            byte1_q, byte1_d;
    logic [7:0]            byte0_q, byte0_d;
    logic                  int_flag_q, int_flag_d;
    logic                  overrun_q, overrun_d;
    logic                  parity_err_q, parity_err_d;

    logic [7:0]            sync_shift;
    logic [15:0]           frame_data;
    logic                  frame_ok;

    assign sync_shift = {sync_q[6:0], bit_value};

    // Without parity the final data bit is still on the wire at completion, so it is spliced in here.
`ifdef RX_PARITY_EN
    assign frame_data = shadow_q;
    assign frame_ok   = ((^shadow_q) == bit_value);
`else
    assign frame_data = {shadow_q, bit_value};
    assign frame_ok   = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        sync_d       = sync_q;
        shadow_d     = shadow_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        byte1_d      = byte1_q;
        byte0_d      = byte0_q;
        int_flag_d   = int_flag_q;
        overrun_d    = overrun_q;
        parity_err_d = parity_err_q;

        // Host acknowledge is applied before any completion in the same cycle.
        if (int_clear) begin
            int_flag_d   = 1'b0;
            overrun_d    = 1'b0;
            parity_err_d = 1'b0;
        end

        if (!rx_enable) begin
            state_d = IDLE;
            sync_d  = 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    sync_d  = 8'h00;
                    state_d = HUNT;
                end
                HUNT: begin
                    if (bit_valid) begin
                        sync_d = sync_shift;
                        if (sync_shift == SYNC_PATTERN) begin
                            state_d   = RECV;
                            shadow_d  = '0;
                            bit_cnt_d = 5'd0;
                            gap_cnt_d = 7'd0;
                        end
                    end
                end
                RECV: begin
                    if (bit_valid) begin
                        gap_cnt_d = 7'd0;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q < 5'(SHADOW_W)) begin
                            shadow_d = {shadow_q[SHADOW_W-2:0], bit_value};
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = HUNT;
                            sync_d  = 8'h00;
                            if (!frame_ok) begin
                                parity_err_d = 1'b1;
                            end else if (int_flag_d) begin
                                overrun_d = 1'b1;
                            end else begin
                                byte1_d    = frame_data[15:8];
                                byte0_d    = frame_data[7:0];
                                int_flag_d = 1'b1;
                            end
                        end
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_d = HUNT;
                        sync_d  = 8'h00;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 7'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge G_CLK_RX or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sync_q       <= 8'h00;
            shadow_q     <= '0;
            bit_cnt_q    <= 5'd0;
            gap_cnt_q    <= 7'd0;
            byte1_q      <= 8'h00;
            byte0_q      <= 8'h00;
            int_flag_q   <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            shadow_q     <= shadow_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            byte1_q      <= byte1_d;
            byte0_q      <= byte0_d;
            int_flag_q   <= int_flag_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign DATA_BYTE_1 = byte1_q;
    assign DATA_BYTE_0 = byte0_q;
    assign status      = (state_q == RECV);
    assign int_flag    = int_flag_q;
    assign int_rx_host = int_flag_q & int_mask;
    assign overrun     = overrun_q;
`ifdef RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
